// File: rtl/capture_dump.sv
// Streams one channel's circular capture trace, oldest sample first, to the UART
// transmitter one byte per send/done handshake, then pulses dump_finished.
module capture_dump #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_dump,
    input  logic [1:0]        dump_channel,
    input  logic [ADDR_W-1:0] trace_end,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ch1_rdata,
    input  logic [7:0]        ch2_rdata,
    input  logic [7:0]        ch3_rdata,
    input  logic              tx_done,
    output logic [7:0]        dump_data,
    output logic              send_dump,
    output logic              dump_finished,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WAIT_TX,
        FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        chan_q, chan_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic              send_q, send_d;
    logic              fin_q, fin_d;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator runs processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            send_q  <= send_d;
            fin_q   <= fin_d;
        end
    end

    // NOTE: every variable gets its hold value or pulse default first, so no
    // path through the case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        send_d  = 1'b0;
        fin_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_dump) begin
                    chan_d = dump_channel;
                    addr_d = trace_end;
                    cnt_d  = '0;
                    if (dump_channel == 2'd3) begin
                        state_d = FINISH;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: state_d = LATCH;

            LATCH: begin
                case (chan_q)
                    2'd0:    data_d = ch1_rdata;
                    2'd1:    data_d = ch2_rdata;
                    default: data_d = ch3_rdata;
                endcase
                send_d  = 1'b1;
                state_d = WAIT_TX;
            end

            WAIT_TX: begin
                if (tx_done) begin
                    // cnt is exactly ADDR_W bits, so all-ones marks the final byte
                    if (cnt_q == '1) begin
                        state_d = FINISH;
                        fin_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = READ;
                    end
                end
            end

            FINISH: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    assign ram_en        = (state_q == READ);
    assign ram_addr      = addr_q;
    assign dump_data     = data_q;
    assign send_dump     = send_q;
    assign dump_finished = fin_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_capture_dump.sv
// Randomized scoreboard bench for capture_dump: a behavioural RAM and UART drive the
// DUT, and a monitor checks bytes, addresses and handshake timing against a model.
module tb_capture_dump;

    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b1;
    logic          start_dump   = 1'b0;
    logic [1:0]    dump_channel = 2'd0;
    logic [AW-1:0] trace_end    = '0;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ch1_rdata    = 8'h00;
    logic [7:0]    ch2_rdata    = 8'h00;
    logic [7:0]    ch3_rdata    = 8'h00;
    logic          tx_done      = 1'b0;
    logic [7:0]    dump_data;
    logic          send_dump;
    logic          dump_finished;
    logic          busy;

    always #5 clk = ~clk;

    capture_dump #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_dump   (start_dump),
        .dump_channel (dump_channel),
        .trace_end    (trace_end),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .ch1_rdata    (ch1_rdata),
        .ch2_rdata    (ch2_rdata),
        .ch3_rdata    (ch3_rdata),
        .tx_done      (tx_done),
        .dump_data    (dump_data),
        .send_dump    (send_dump),
        .dump_finished(dump_finished),
        .busy         (busy)
    );

    // Behavioural channel RAMs: registered read, data valid the cycle after ram_en.
    logic [7:0] mem [3][DEPTH];

    always @(posedge clk) begin
        if (ram_en) begin
            ch1_rdata <= mem[0][ram_addr];
            ch2_rdata <= mem[1][ram_addr];
            ch3_rdata <= mem[2][ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and reference model state.
    logic [7:0]    exp_q[$];
    int            cyc        = 0;
    int            exp_send   = -1;
    int            exp_fin    = -1;
    int            idx        = 0;
    int            fin_count  = 0;
    int            dump_sends = 0;
    int            pending_tx = 0;
    logic [AW-1:0] base       = '0;
    bit            awaiting   = 1'b0;
    bit            busy_prev  = 1'b0;
    bit            exp_ram;

    // UART model knobs.
    int tx_min   = 3;
    int tx_max   = 3;
    bit spurious = 1'b0;

    // Monitor: looks just after each edge; inputs seen are those the edge sampled.
    initial forever begin
        @(posedge clk or negedge rst_n);
        #1;
        if (!rst_n) begin
            check("reset_outputs",
                  {11'd0, ram_en, ram_addr, dump_data, send_dump, dump_finished, busy}, 32'd0);
            exp_send   = -1;
            exp_fin    = -1;
            awaiting   = 1'b0;
            busy_prev  = 1'b0;
            pending_tx = 0;
        end else begin
            cyc++;
            exp_ram = 1'b0;
            if (start_dump && !busy_prev) begin
                base       = trace_end;
                idx        = 0;
                dump_sends = 0;
                if (dump_channel == 2'd3) begin
                    exp_fin = cyc;
                end else begin
                    exp_ram  = 1'b1;
                    exp_send = cyc + 2;
                end
            end else if (tx_done && awaiting) begin
                awaiting = 1'b0;
                idx++;
                if (idx == DEPTH) begin
                    exp_fin = cyc;
                end else begin
                    exp_ram  = 1'b1;
                    exp_send = cyc + 2;
                end
            end

            if (ram_en || exp_ram) begin
                check("ram_en", {31'd0, ram_en}, {31'd0, exp_ram});
                check("ram_addr", {23'd0, ram_addr}, {23'd0, base + AW'(idx)});
            end

            if (send_dump || cyc == exp_send) begin
                check("send_timing", {31'd0, send_dump}, {31'd0, cyc == exp_send});
                if (send_dump) begin
                    awaiting = 1'b1;
                    pending_tx++;
                    dump_sends++;
                    check("busy_during_send", {31'd0, busy}, 32'd1);
                    if (exp_q.size() > 0) begin
                        check("dump_data", {24'd0, dump_data}, {24'd0, exp_q.pop_front()});
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got byte 0x%0h, expected no byte (t=%0t)",
                                 dump_data, $time);
                    end
                end
            end

            if (dump_finished || cyc == exp_fin) begin
                check("finish_timing", {31'd0, dump_finished}, {31'd0, cyc == exp_fin});
                if (dump_finished) begin
                    fin_count++;
                    check("bytes_left_at_finish", exp_q.size(), 0);
                end
            end

            if (exp_fin >= 0 && cyc == exp_fin + 1)
                check("busy_after_finish", {31'd0, busy}, 32'd0);

            busy_prev = busy;
        end
    end

    // UART model: answers each send_dump with tx_done after a delay, optionally
    // followed by a stray pulse that lands while the DUT is fetching.
    initial forever begin
        @(negedge clk);
        if (pending_tx > 0) begin
            pending_tx--;
            repeat ($urandom_range(tx_max, tx_min)) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (spurious && $urandom_range(0, 1) == 1) begin
                @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    task automatic push_expected(input logic [1:0] ch, input logic [AW-1:0] te);
        if (ch != 2'd3)
            for (int i = 0; i < DEPTH; i++)
                exp_q.push_back(mem[ch][(int'(te) + i) % DEPTH]);
    endtask

    task automatic issue_start(input logic [1:0] ch, input logic [AW-1:0] te);
        @(negedge clk);
        start_dump   = 1'b1;
        dump_channel = ch;
        trace_end    = te;
        @(negedge clk);
        start_dump   = 1'b0;
    endtask

    task automatic run_dump(input logic [1:0] ch, input logic [AW-1:0] te, input bit disturb);
        int target;
        push_expected(ch, te);
        target = fin_count + 1;
        issue_start(ch, te);
        for (int c = 0; c < 12000 && fin_count < target; c++) begin
            if (disturb && busy && $urandom_range(0, 63) == 0) begin
                start_dump   = 1'b1;
                dump_channel = 2'($urandom);
                trace_end    = AW'($urandom);
                @(negedge clk);
                start_dump   = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("dump_completed", fin_count, target);
        check("bytes_per_dump", dump_sends, (ch == 2'd3) ? 0 : DEPTH);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fin_before;
        logic [AW-1:0] te;

        // Reset, then a quiet idle stretch: any stray output is flagged by the monitor.
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_finish", fin_count, 0);
        check("idle_no_send", dump_sends, 0);

        // Incrementing pattern on CH2 from address 0, fixed UART latency.
        for (int i = 0; i < DEPTH; i++) mem[1][i] = 8'(i);
        run_dump(2'd1, 9'h000, 1'b0);

        // Wrap-around on CH1 starting near the top of the buffer.
        for (int i = 0; i < DEPTH; i++) mem[0][i] = 8'(i >> 1);
        run_dump(2'd0, 9'h1F0, 1'b0);

        // Channel select with constant RAM contents, same-cycle tx_done.
        for (int i = 0; i < DEPTH; i++) begin
            mem[0][i] = 8'hA1;
            mem[1][i] = 8'hB2;
            mem[2][i] = 8'hC3;
        end
        tx_min = 0;
        tx_max = 0;
        run_dump(2'd0, AW'($urandom), 1'b0);
        run_dump(2'd1, AW'($urandom), 1'b0);
        run_dump(2'd2, AW'($urandom), 1'b0);
        run_dump(2'd3, AW'($urandom), 1'b0);

        // Random contents, random latency, stray tx_done and mid-dump disturbance.
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < DEPTH; i++) mem[c][i] = 8'($urandom);
        tx_min   = 0;
        tx_max   = 3;
        spurious = 1'b1;
        for (int k = 0; k < 2; k++)
            run_dump(2'($urandom_range(0, 2)), AW'($urandom), 1'b1);

        // Reset after byte 100 abandons the dump with no completion pulse.
        spurious   = 1'b0;
        fin_before = fin_count;
        te         = AW'($urandom);
        push_expected(2'd2, te);
        issue_start(2'd2, te);
        for (int c = 0; c < 3000 && dump_sends < 100; c++) @(negedge clk);
        check("reached_byte_100", {31'd0, dump_sends >= 100}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_finish_after_reset", fin_count, fin_before);

        // A fresh full dump from a new trace_end after the abandoned one.
        run_dump(2'd0, te + AW'(37), 1'b0);

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
